// File: rtl/alu_pkg.sv
// Shared control-code encoding, FSM state type and decode helpers for alu_multicycle.
package alu_pkg;

    localparam logic [3:0] ALU_AND   = 4'd0;
    localparam logic [3:0] ALU_OR    = 4'd1;
    localparam logic [3:0] ALU_ADD   = 4'd2;
    localparam logic [3:0] ALU_MUL   = 4'd3;
    localparam logic [3:0] ALU_MULHU = 4'd4;
    localparam logic [3:0] ALU_DIVU  = 4'd5;
    localparam logic [3:0] ALU_SUB   = 4'd6;
    localparam logic [3:0] ALU_SLTU  = 4'd7;
    localparam logic [3:0] ALU_REMU  = 4'd8;
    localparam logic [3:0] ALU_SLT   = 4'd9;
    localparam logic [3:0] ALU_NOR   = 4'd12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } state_t;

    // Codes that normally need the shift/add engine (divide-by-zero is the exception).
    function automatic logic is_iterative(input logic [3:0] code);
        return (code == ALU_MUL) || (code == ALU_MULHU) ||
               (code == ALU_DIVU) || (code == ALU_REMU);
    endfunction

    function automatic logic is_divide(input logic [3:0] code);
        return (code == ALU_DIVU) || (code == ALU_REMU);
    endfunction

endpackage

// File: rtl/alu_multicycle_if.sv
// Request/result bundle between the execute-stage control and alu_multicycle.
interface alu_multicycle_if #(
    parameter int WIDTH = 32
);
    logic             Start;
    logic [3:0]       Control;
    logic [WIDTH-1:0] Input1;
    logic [WIDTH-1:0] Input2;
    logic [WIDTH-1:0] Out;
    logic             Zero;
    logic             Busy;
    logic             Done;
    logic             Illegal;

    modport master (
        output Start, Control, Input1, Input2,
        input  Out, Zero, Busy, Done, Illegal
    );

    modport slave (
        input  Start, Control, Input1, Input2,
        output Out, Zero, Busy, Done, Illegal
    );
endinterface

// File: rtl/alu_muldiv_seq.sv
// Iterative unsigned multiply / restoring divide engine, one bit per cycle.
// The hi/lo pair is shared: for MUL it is the {upper partial, multiplier} product
// register, for DIV it is {remainder, quotient/dividend}. o_hi/o_lo present the
// result of the step being taken this cycle, so the caller can capture the final
// value on the same edge the counter expires.
module alu_muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_is_div,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_last,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);
    localparam int         CW   = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LOAD = CW'(WIDTH);

    logic [CW-1:0]    r_cnt;
    logic             r_div;
    logic [WIDTH-1:0] r_m;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_sh;
    logic             w_ge;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_hi_nxt;
    logic [WIDTH-1:0] w_lo_nxt;

    // One step of shift-add (multiply) or shift-subtract (divide).
    always_comb begin
        w_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_m} : '0);
        w_sh   = {r_hi, r_lo[WIDTH-1]};
        w_ge   = (w_sh >= {1'b0, r_m});
        // When w_ge holds the true difference is below the divisor, so the low bits suffice.
        w_diff = w_sh[WIDTH-1:0] - r_m;
        if (r_div) begin
            w_hi_nxt = w_ge ? w_diff : w_sh[WIDTH-1:0];
            w_lo_nxt = {r_lo[WIDTH-2:0], w_ge};
        end else begin
            w_hi_nxt = w_sum[WIDTH:1];
            w_lo_nxt = {w_sum[0], r_lo[WIDTH-1:1]};
        end
    end

    assign o_last = (r_cnt == CW'(1));
    assign o_hi   = w_hi_nxt;
    assign o_lo   = w_lo_nxt;

    // Load operands on start, then iterate until the counter drains.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_div <= 1'b0;
            r_m   <= '0;
            r_hi  <= '0;
            r_lo  <= '0;
        end else if (i_start) begin
            r_cnt <= LOAD;
            r_div <= i_is_div;
            r_hi  <= '0;
            r_lo  <= i_is_div ? i_a : i_b;
            r_m   <= i_is_div ? i_b : i_a;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
            r_hi  <= w_hi_nxt;
            r_lo  <= w_lo_nxt;
        end
    end
endmodule

// File: rtl/alu_multicycle.sv
// Execute-stage ALU: single-cycle logic/arith ops plus iterative MUL/MULHU/DIVU/REMU
// behind a Start/Busy/Done handshake. Out, Done and Illegal are registered.
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic              Clock,
    input  logic              Reset,
    alu_multicycle_if.slave   bus
);
    state_t           r_state;
    state_t           w_state_nxt;
    logic [3:0]       r_op;
    logic [WIDTH-1:0] r_out;
    logic             r_done;
    logic             r_illegal;

    logic             w_accept;
    logic             w_divz;
    logic             w_go_mul;
    logic             w_go_div;
    logic             w_seq_last;
    logic [WIDTH-1:0] w_seq_hi;
    logic [WIDTH-1:0] w_seq_lo;
    logic [WIDTH-1:0] w_sc_res;
    logic             w_sc_ill;
    logic             w_wr_en;
    logic [WIDTH-1:0] w_wr_data;
    logic             w_wr_ill;

    assign w_accept = bus.Start && (r_state == ST_IDLE);
    assign w_divz   = is_divide(bus.Control) && (bus.Input2 == '0);
    assign w_go_mul = w_accept && is_iterative(bus.Control) && !is_divide(bus.Control);
    assign w_go_div = w_accept && is_divide(bus.Control) && !w_divz;

    alu_muldiv_seq #(.WIDTH(WIDTH)) u_seq (
        .clk      (Clock),
        .rst      (Reset),
        .i_start  (w_go_mul || w_go_div),
        .i_is_div (w_go_div),
        .i_a      (bus.Input1),
        .i_b      (bus.Input2),
        .o_last   (w_seq_last),
        .o_hi     (w_seq_hi),
        .o_lo     (w_seq_lo)
    );

    // Single-cycle results, including the divide-by-zero shortcuts and the illegal fill.
    always_comb begin
        w_sc_res = '1;
        w_sc_ill = 1'b0;
        case (bus.Control)
            ALU_AND:   w_sc_res = bus.Input1 & bus.Input2;
            ALU_OR:    w_sc_res = bus.Input1 | bus.Input2;
            ALU_ADD:   w_sc_res = bus.Input1 + bus.Input2;
            ALU_SUB:   w_sc_res = bus.Input1 - bus.Input2;
            ALU_SLTU:  w_sc_res = WIDTH'(bus.Input1 < bus.Input2);
            ALU_SLT:   w_sc_res = WIDTH'($signed(bus.Input1) < $signed(bus.Input2));
            ALU_NOR:   w_sc_res = ~(bus.Input1 | bus.Input2);
            ALU_DIVU:  w_sc_res = '1;
            ALU_REMU:  w_sc_res = bus.Input1;
            ALU_MUL,
            ALU_MULHU: w_sc_res = '0;
            default:   w_sc_ill = 1'b1;
        endcase
    end

    // FSM state register.
    always_ff @(posedge Clock) begin
        if (Reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    // FSM next state.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_go_mul)      w_state_nxt = ST_MUL;
                else if (w_go_div) w_state_nxt = ST_DIV;
            end
            ST_MUL,
            ST_DIV:  if (w_seq_last) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs: when and what to write into the result registers.
    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_data = '0;
        w_wr_ill  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && !(w_go_mul || w_go_div)) begin
                    w_wr_en   = 1'b1;
                    w_wr_data = w_sc_res;
                    w_wr_ill  = w_sc_ill;
                end
            end
            ST_MUL: begin
                w_wr_en   = w_seq_last;
                w_wr_data = (r_op == ALU_MULHU) ? w_seq_hi : w_seq_lo;
            end
            ST_DIV: begin
                w_wr_en   = w_seq_last;
                w_wr_data = (r_op == ALU_REMU) ? w_seq_hi : w_seq_lo;
            end
            default: ;
        endcase
    end

    // Latch the opcode at acceptance so the completion half/result select ignores later changes.
    always_ff @(posedge Clock) begin
        if (Reset)         r_op <= ALU_AND;
        else if (w_accept) r_op <= bus.Control;
    end

    // Result registers; Done pulses on every write.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_out     <= '0;
            r_illegal <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= w_wr_en;
            if (w_wr_en) begin
                r_out     <= w_wr_data;
                r_illegal <= w_wr_ill;
            end
        end
    end

    assign bus.Out     = r_out;
    assign bus.Zero    = (r_out == '0);
    assign bus.Busy    = (r_state != ST_IDLE);
    assign bus.Done    = r_done;
    assign bus.Illegal = r_illegal;
endmodule

// File: tb/tb_alu_multicycle.sv
// Directed bench for alu_multicycle at WIDTH=32 and WIDTH=8.
module tb_alu_multicycle;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   n;

    always #5 clk = ~clk;

    alu_multicycle_if #(.WIDTH(32)) b32 ();
    alu_multicycle_if #(.WIDTH(8))  b8  ();

    alu_multicycle #(.WIDTH(32)) dut32 (.Clock(clk), .Reset(rst), .bus(b32));
    alu_multicycle #(.WIDTH(8))  dut8  (.Clock(clk), .Reset(rst), .bus(b8));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        b32.Start = 1'b1; b32.Control = c; b32.Input1 = a; b32.Input2 = b;
        step();
        b32.Start = 1'b0;
    endtask

    task automatic issue8(input logic [3:0] c, input logic [7:0] a, input logic [7:0] b);
        b8.Start = 1'b1; b8.Control = c; b8.Input1 = a; b8.Input2 = b;
        step();
        b8.Start = 1'b0;
    endtask

    task automatic wait32(input int budget, output int cyc);
        cyc = 0;
        while (!b32.Done && cyc < budget) begin step(); cyc++; end
    endtask

    task automatic wait8(input int budget, output int cyc);
        cyc = 0;
        while (!b8.Done && cyc < budget) begin step(); cyc++; end
    endtask

    initial begin
        b32.Start = 0; b32.Control = 0; b32.Input1 = 0; b32.Input2 = 0;
        b8.Start  = 0; b8.Control  = 0; b8.Input1  = 0; b8.Input2  = 0;
        repeat (3) step();
        rst = 1'b0;

        // Reset state
        chk("rst_out",  b32.Out, 0);
        chk("rst_zero", b32.Zero, 1);
        chk("rst_busy", b32.Busy, 0);
        chk("rst_done", b32.Done, 0);
        chk("rst_ill",  b32.Illegal, 0);
        chk("rst8_out", b8.Out, 0);

        // Reset mid-MUL at cycle 10: aborts, no Done, Out stays at 0
        issue(ALU_MUL, 32'd3, 32'd5);
        chk("abort_busy0", b32.Busy, 1);
        repeat (9) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_busy", b32.Busy, 0);
        chk("abort_done", b32.Done, 0);
        chk("abort_out",  b32.Out, 0);
        n = 0;
        repeat (40) begin step(); if (b32.Done) n++; end
        chk("abort_no_done", n, 0);

        // Single-cycle ops, ADD and SUB back to back
        issue(ALU_ADD, 32'hFFFF_FFFF, 32'd1);
        chk("add_done", b32.Done, 1);
        chk("add_out",  b32.Out, 0);
        chk("add_zero", b32.Zero, 1);
        issue(ALU_SUB, 32'd5, 32'd7);
        chk("sub_done", b32.Done, 1);
        chk("sub_out",  b32.Out, 32'hFFFF_FFFE);
        chk("sub_zero", b32.Zero, 0);
        step();
        chk("sub_done_pulse", b32.Done, 0);
        chk("sub_out_hold",   b32.Out, 32'hFFFF_FFFE);
        issue(ALU_SLT, 32'hFFFF_FFFF, 32'd1);
        chk("slt_out", b32.Out, 1);
        issue(ALU_SLTU, 32'hFFFF_FFFF, 32'd1);
        chk("sltu_out", b32.Out, 0);
        issue(ALU_OR, 32'hF0, 32'h0F);
        chk("or_out", b32.Out, 32'hFF);
        issue(ALU_NOR, 32'h0, 32'h0);
        chk("nor_out", b32.Out, 32'hFFFF_FFFF);

        // Multiply
        issue(ALU_MUL, 32'h0001_0000, 32'h0001_0000);
        chk("mul_busy", b32.Busy, 1);
        chk("mul_done0", b32.Done, 0);
        wait32(40, n);
        chk("mul_lat",  n, 32);
        chk("mul_out",  b32.Out, 0);
        chk("mul_zero", b32.Zero, 1);
        chk("mul_busy_end", b32.Busy, 0);
        step();
        chk("mul_done_pulse", b32.Done, 0);
        issue(ALU_MULHU, 32'h0001_0000, 32'h0001_0000);
        wait32(40, n);
        chk("mulhu_lat", n, 32);
        chk("mulhu_out", b32.Out, 1);
        issue(ALU_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait32(40, n);
        chk("mul_ff_out", b32.Out, 1);
        issue(ALU_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait32(40, n);
        chk("mulhu_ff_out", b32.Out, 32'hFFFF_FFFE);

        // Divide with Start and operand changes while busy
        issue(ALU_DIVU, 32'd100, 32'd7);
        repeat (4) step();
        b32.Start = 1'b1; b32.Control = ALU_ADD; b32.Input1 = 32'd1; b32.Input2 = 32'd1;
        step();
        b32.Start = 1'b0; b32.Input1 = 32'hDEAD;
        chk("divu_busy_mid", b32.Busy, 1);
        chk("divu_no_early", b32.Done, 0);
        wait32(40, n);
        chk("divu_lat", n + 5, 32);
        chk("divu_out", b32.Out, 14);
        issue(ALU_REMU, 32'd100, 32'd7);
        wait32(40, n);
        chk("remu_lat", n, 32);
        chk("remu_out", b32.Out, 2);
        issue(ALU_DIVU, 32'hFFFF_FFFF, 32'd1);
        wait32(40, n);
        chk("divu_max_out", b32.Out, 32'hFFFF_FFFF);
        issue(ALU_REMU, 32'hFFFF_FFFF, 32'h10);
        wait32(40, n);
        chk("remu_max_out", b32.Out, 32'hF);

        // Divide by zero is single-cycle
        issue(ALU_DIVU, 32'd5, 32'd0);
        chk("divz_done", b32.Done, 1);
        chk("divz_busy", b32.Busy, 0);
        chk("divz_out",  b32.Out, 32'hFFFF_FFFF);
        chk("divz_ill",  b32.Illegal, 0);
        issue(ALU_REMU, 32'd5, 32'd0);
        chk("remz_out", b32.Out, 5);

        // Illegal codes
        issue(4'd10, 32'd1, 32'd2);
        chk("ill_done", b32.Done, 1);
        chk("ill_out",  b32.Out, 32'hFFFF_FFFF);
        chk("ill_flag", b32.Illegal, 1);
        step();
        chk("ill_hold", b32.Illegal, 1);
        issue(ALU_AND, 32'hF0, 32'h3C);
        chk("and_out", b32.Out, 32'h30);
        chk("and_ill", b32.Illegal, 0);
        issue(4'd15, 32'd0, 32'd0);
        chk("ill15_flag", b32.Illegal, 1);
        issue(ALU_MUL, 32'd2, 32'd3);
        chk("ill_hold_busy", b32.Illegal, 1);
        wait32(40, n);
        chk("mul_small_out", b32.Out, 6);
        chk("mul_clears_ill", b32.Illegal, 0);

        // WIDTH=8 instance
        issue8(ALU_MUL, 8'd15, 8'd17);
        chk("w8_mul_busy", b8.Busy, 1);
        wait8(20, n);
        chk("w8_mul_lat", n, 8);
        chk("w8_mul_out", b8.Out, 8'hFF);
        chk("w8_mul_zero", b8.Zero, 0);
        issue8(ALU_MULHU, 8'd15, 8'd17);
        wait8(20, n);
        chk("w8_mulhu_out", b8.Out, 0);
        chk("w8_mulhu_zero", b8.Zero, 1);
        issue8(ALU_DIVU, 8'd255, 8'd16);
        wait8(20, n);
        chk("w8_divu_lat", n, 8);
        chk("w8_divu_out", b8.Out, 8'd15);
        issue8(4'd11, 8'd0, 8'd0);
        chk("w8_ill_out", b8.Out, 8'hFF);
        chk("w8_ill_flag", b8.Illegal, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
